// File: rtl/regwrite_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: write-port field
// widths, the reserved PC register address and the requester index type.
package regwrite_arbiter_pkg;

    // Register-bank write-port field widths.
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    // Register address reserved for the PC; writes to it are refused.
    localparam logic [ADDR_W-1:0] R15_ADDR_DEF = 4'hF;

    // Requester index, also the encoding of the round-robin pointer.
    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_idx_e;

endpackage : regwrite_arbiter_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational and one-hot. A
// 1-bit pointer remembers which requester won last. It moves only when a
// grant is issued, which is when a transfer is accepted.
module rr_arbiter2
    import regwrite_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_idx_e last_q;
    req_idx_e last_d;

    // Grant the sole requester. When both are valid, grant the one that did not win last.
    // NOTE: every output of a combinational block is given a default first so no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == REQ_ALU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Move the pointer to whichever requester was just granted.
    always_comb begin
        last_d = last_q;
        if (gnt[0]) begin
            last_d = REQ_ALU;
        end else if (gnt[1]) begin
            last_d = REQ_LOAD;
        end
    end

    // Pointer register. Reset marks requester 1 as the last winner, so requester 0 is preferred next.
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_LOAD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule : rr_arbiter2

// File: rtl/regwrite_arbiter.sv
// Arbitrates writes from two requesters (ALU writeback, load/IO) onto a
// single register-bank write port. The write port is registered, so an
// accepted write is presented one cycle later. The block refuses PC (R15)
// writes and flags them, counts committed writes, and raises a read-after-write
// stall for decode.
module regwrite_arbiter
    import regwrite_arbiter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] R15_ADDR = R15_ADDR_DEF,
    parameter int                CNT_W    = 8
)
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,

    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,

    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,

    output logic              stall,
    output logic              err_r15,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  wr_count
);

    logic [1:0]        gnt_raw;
    logic [1:0]        gnt;
    logic              acc_valid;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_r15;

    logic              we3_q,   we3_d;
    logic [ADDR_W-1:0] a3_q,    a3_d;
    logic [DATA_W-1:0] wd3_q,   wd3_d;
    logic              err_q,   err_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    rr_arbiter2 u_rr_arbiter2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1_valid, req0_valid}),
        .gnt   (gnt_raw)
    );

    // Qualify the grant with reset so that no request is acknowledged while the block is held in reset.
    always_comb begin
        gnt        = gnt_raw & {2{rst_n}};
        req0_ready = gnt[0];
        req1_ready = gnt[1];
    end

    // Select the address and data of the accepted transfer, if there is one.
    always_comb begin
        acc_valid = |gnt;
        acc_addr  = gnt[1] ? req1_addr : req0_addr;
        acc_data  = gnt[1] ? req1_data : req0_data;
        acc_r15   = acc_valid && (acc_addr == R15_ADDR);
    end

    // Next write-port state. A3/WD3 change only when a real write is issued.
    always_comb begin
        we3_d = acc_valid && !acc_r15;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (we3_d) begin
            a3_d  = acc_addr;
            wd3_d = acc_data;
        end
    end

    // Sticky R15 error flag. A new attempt overrides a clear in the same cycle.
    always_comb begin
        err_d = err_q;
        if (acc_r15) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    // Committed-write counter. It steps on the same edge that raises WE3 and wraps naturally.
    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, we3_d};
    end

    // Stall decode on a hit against the write being presented or the write being accepted. R15 never matches.
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            if (we3_q && (a3_q != R15_ADDR) && ((ra1 == a3_q) || (ra2 == a3_q))) begin
                stall = 1'b1;
            end
            if (acc_valid && !acc_r15 && ((ra1 == acc_addr) || (ra2 == acc_addr))) begin
                stall = 1'b1;
            end
        end
    end

    // Output register stage, error flag and counter. Asynchronous reset drops any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    // Drive the output ports from the registers.
    always_comb begin
        WE3      = we3_q;
        A3       = a3_q;
        WD3      = wd3_q;
        err_r15  = err_q;
        wr_count = cnt_q;
    end

endmodule : regwrite_arbiter

// File: tb/tb_regwrite_arbiter.sv
// Directed testbench for regwrite_arbiter. Each step drives one cycle of
// stimulus and checks the combinational ready and stall outputs against a
// reference model. It pushes the expected write-port effect to a
// scoreboard, then pops and compares that effect after the clock edge.
module tb_regwrite_arbiter;

    localparam logic [3:0] R15 = 4'hF;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        r15;
        logic        clr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [3:0]  ra1, ra2;
    logic        WE3;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic        stall, err_r15, clr_err;
    logic [7:0]  wr_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    exp_t        sb[$];
    logic        m_last;
    logic        m_we;
    logic [3:0]  m_a3;
    logic [31:0] m_wd3;
    logic        m_err;
    logic [7:0]  m_cnt;

    regwrite_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .ra1        (ra1),
        .ra2        (ra2),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .stall      (stall),
        .err_r15    (err_r15),
        .clr_err    (clr_err),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        ra1 = '0; ra2 = '0; clr_err = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        m_last = 1'b1;
        m_we   = 1'b0;
        m_a3   = '0;
        m_wd3  = '0;
        m_err  = 1'b0;
        m_cnt  = '0;
    endtask

    function automatic logic [1:0] model_grant(input logic v0, input logic v1);
        if (v0 && v1) return m_last ? 2'b01 : 2'b10;
        return {v1, v0};
    endfunction

    // Start and end at posedge+1. Run one cycle and check it.
    task automatic step(input logic v0, input logic [3:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [3:0] a1, input logic [31:0] d1,
                        input logic [3:0] r1, input logic [3:0] r2, input logic clr);
        exp_t        e;
        logic [1:0]  g;
        logic [3:0]  ga;
        logic [31:0] gd;
        logic        s;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        ra1 = r1; ra2 = r2; clr_err = clr;
        #1;
        g  = model_grant(v0, v1);
        ga = g[1] ? a1 : a0;
        gd = g[1] ? d1 : d0;
        s  = (m_we && (m_a3 != R15) && ((r1 == m_a3) || (r2 == m_a3))) ||
             ((g != 2'b00) && (ga != R15) && ((r1 == ga) || (r2 == ga)));
        check("req0_ready", 32'(req0_ready), 32'(g[0]));
        check("req1_ready", 32'(req1_ready), 32'(g[1]));
        check("stall", 32'(stall), 32'(s));
        if (g != 2'b00) m_last = g[1];
        e.we   = (g != 2'b00) && (ga != R15);
        e.addr = ga;
        e.data = gd;
        e.r15  = (g != 2'b00) && (ga == R15);
        e.clr  = clr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        drive_idle();
        e = sb.pop_front();
        m_we = e.we;
        if (e.we) begin
            m_a3  = e.addr;
            m_wd3 = e.data;
            m_cnt = m_cnt + 8'd1;
        end
        if (e.r15) m_err = 1'b1;
        else if (e.clr) m_err = 1'b0;
        check("WE3", 32'(WE3), 32'(m_we));
        check("A3", 32'(A3), 32'(m_a3));
        check("WD3", WD3, m_wd3);
        check("err_r15", 32'(err_r15), 32'(m_err));
        check("wr_count", 32'(wr_count), 32'(m_cnt));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        req0_valid = 1'b1; req0_addr = 4'd3; ra1 = 4'd3;
        req1_valid = 1'b1; req1_addr = 4'd3;
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_WE3", 32'(WE3), 32'd0);
        check("rst_A3", 32'(A3), 32'd0);
        check("rst_WD3", WD3, 32'd0);
        check("rst_err_r15", 32'(err_r15), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        do_reset();

        // req0 alone: addr 3, data AA, written in the next cycle, count becomes 1
        step(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        check("single_A3", 32'(A3), 32'd3);
        check("single_WD3", WD3, 32'hAA);
        check("single_count", 32'(wr_count), 32'd1);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);

        // Both requesters valid for 4 cycles after reset: grants go 0,1,0,1 and A3 goes 1,2,1,2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'd1, 32'h1111_0001, 1'b1, 4'd2, 32'h2222_0002, 4'd0, 4'd0, 1'b0);
            check("rr_A3_seq", 32'(A3), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        // Same address from both requesters is not merged: two separate writes
        step(1'b1, 4'd9, 32'hAAAA_0009, 1'b1, 4'd9, 32'hBBBB_0009, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd9, 32'hAAAA_0009, 1'b1, 4'd9, 32'hBBBB_0009, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);

        // Stall on the presented write (A3=5, ra2=5), then on the accepted write (addr 6, ra1=6)
        step(1'b1, 4'd5, 32'h0000_0055, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd5, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h0000_0066, 4'd6, 4'd0, 1'b0);

        // R15 write from req1: accepted but not written, err set; ra1=F does not stall
        step(1'b0, 4'd0, 32'd0, 1'b1, R15, 32'hDEAD_BEEF, R15, 4'd0, 1'b0);
        check("r15_no_we", 32'(WE3), 32'd0);
        check("r15_err_set", 32'(err_r15), 32'd1);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, R15, R15, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1);
        check("r15_err_cleared", 32'(err_r15), 32'd0);
        step(1'b0, 4'd0, 32'd0, 1'b1, R15, 32'h0BAD_0BAD, 4'd0, 4'd0, 1'b0);
        step(1'b1, R15, 32'h0000_F00D, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1);
        check("r15_set_wins", 32'(err_r15), 32'd1);

        // Counter wrap: 255 writes bring it to 255, one more brings it to 0
        do_reset();
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 4'(i % 15), 32'(i), 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        end
        check("count_at_255", 32'(wr_count), 32'd255);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h0000_0777, 4'd0, 4'd0, 1'b0);
        check("count_wrapped", 32'(wr_count), 32'd0);

        // Reset mid-cycle while a write is presented: WE3 drops at once and the write is never replayed
        step(1'b1, 4'd7, 32'h7777_7777, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        check("pre_reset_WE3", 32'(WE3), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_WE3", 32'(WE3), 32'd0);
        check("async_A3", 32'(A3), 32'd0);
        check("async_count", 32'(wr_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_WE3", 32'(WE3), 32'd0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        step(1'b1, 4'd8, 32'h0000_0088, 1'b1, 4'd9, 32'h0000_0099, 4'd0, 4'd0, 1'b0);
        check("post_reset_grant_A3", 32'(A3), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regwrite_arbiter

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 The block SHALL have parameter R15_ADDR, default 4'hF, meaning the register address reserved for the PC (read-only).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the write counter.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 The block SHALL have ports req0_valid / req1_valid  input  1 each  meaning requester 0 (ALU writeback) / requester 1 (load/IO) has a write.
REQ-006 The block SHALL have ports req0_addr / req1_addr  input  4 each  meaning the destination register.
REQ-007 The block SHALL have ports req0_data / req1_data  input  32 each  meaning the write data.
REQ-008 The block SHALL have ports req0_ready / req1_ready  output  1 each  meaning the request is accepted this cycle.
REQ-009 The block SHALL have ports ra1 / ra2  input  4 each  meaning the decode read addresses, used for hazard check.
REQ-010 The block SHALL have ports WE3  output  1, A3  output  4, WD3  output  32, meaning the register-bank write port.
REQ-011 The block SHALL have port stall  output  1  meaning a decode read hits an in-flight write.
REQ-012 The block SHALL have port err_r15  output  1  meaning a sticky flag: a write to R15_ADDR was attempted.
REQ-013 The block SHALL have port clr_err  input  1  meaning clear err_r15.
REQ-014 The block SHALL have port wr_count  output  CNT_W  meaning the number of writes committed to the bank.

Function
REQ-015 Handshake: a transfer SHALL occur when valid && ready in the same cycle; readyN SHALL be combinational and high for at most one requester per cycle.
REQ-016 A requester SHALL hold valid, addr and data stable until it is accepted; the block SHALL NOT accept a request whose valid is low.
REQ-017 Arbitration SHALL be round-robin with a 1-bit last-grant pointer: a sole valid requester is granted; when both are valid, the requester not granted last is granted.
REQ-018 The pointer SHALL update only on an accepted transfer.
REQ-019 Equal addresses from both requesters SHALL NOT be merged; the loser SHALL be written on a later cycle.
REQ-020 Latency: a transfer accepted in cycle N SHALL drive WE3=1, A3=addr, WD3=data from registers during cycle N+1 only.
REQ-021 With no transfer in cycle N, WE3 SHALL be 0 in N+1, and A3/WD3 SHALL hold their last values.
REQ-022 Back-to-back transfers SHALL sustain one write per cycle.
REQ-023 A transfer with addr == R15_ADDR SHALL be accepted (ready high), SHALL NOT assert WE3, and SHALL set err_r15 in N+1.
REQ-024 err_r15 SHALL remain set until clr_err is sampled high; if set and clear occur in the same cycle, set SHALL win.
REQ-025 wr_count SHALL increment by 1 in the cycle WE3 is driven high and SHALL wrap from all-ones to 0.
REQ-026 stall SHALL be combinational and high when WE3=1 and (ra1==A3 or ra2==A3), or when an accepted transfer's addr this cycle equals ra1 or ra2.
REQ-027 stall SHALL ignore matches on R15_ADDR.

Reset
REQ-028 On rst_n low, asynchronously: WE3=0, A3=0, WD3=0, err_r15=0, wr_count=0, and the pointer SHALL select requester 0 as next preferred.
REQ-029 While rst_n is low, req0_ready, req1_ready and stall SHALL be 0.
REQ-030 A write registered but not yet presented when reset asserts SHALL be discarded, never replayed.

Structure
REQ-031 A shared package SHALL hold R15_ADDR, the requester-index type (REQ_ALU=0, REQ_LOAD=1) and the write-port field widths (4 and 32).
REQ-032 The grant logic SHALL be one sub-module, rr_arbiter2 (2 requests in, one-hot grant out, pointer register inside); the output register stage, error flag and counter SHALL remain in regwrite_arbiter.

Verification
REQ-033 The bench SHALL cover: req0 only, addr=3, data=32'h0000_00AA -> req0_ready=1 in cycle N; WE3=1, A3=3, WD3=32'hAA in N+1; wr_count=1.
REQ-034 The bench SHALL cover: both valid for 4 cycles, addrs 1/2, after reset -> grants alternate 0,1,0,1; A3 sequence 1,2,1,2 on consecutive cycles.
REQ-035 The bench SHALL cover: req1 addr=4'hF -> req1_ready=1, WE3 stays 0, err_r15=1 next cycle; clr_err pulse -> 0; clr_err plus a new R15 attempt in the same cycle -> stays 1.
REQ-036 The bench SHALL cover: WE3=1 with A3=5 and ra2=5 -> stall=1; A3=4'hF, ra1=4'hF -> stall=0.
REQ-037 The bench SHALL cover: wr_count preloaded to 255 by 255 writes, one more write -> wr_count=0.
REQ-038 The bench SHALL cover: rst_n pulled low mid-cycle after a grant -> WE3=0 immediately; no write appears after release; the first grant after release goes to req0 when both are valid.
